// File: rtl/snake_pkg.sv
// Shared snake-game constants, food FSM encoding and a BCD score helper.
// The SCORE_BCD_EN macro selects the packed-BCD score format.
package snake_pkg;

  localparam int unsigned CW  = 10;
  localparam int unsigned BLK = 8;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_V_ACTIVE = 480;

  typedef enum logic [1:0] {
    StInit    = 2'd0,
    StArmed   = 2'd1,
    StRespawn = 2'd2
  } food_state_e;

`ifdef SCORE_BCD_EN
  localparam logic [15:0] SCORE_MAX = 16'h9999;
`else
  localparam logic [15:0] SCORE_MAX = 16'hFFFF;
`endif

  // Ripple a +1 through four packed BCD digits.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational square-vs-square overlap: |dx| < BLK and |dy| < BLK.
// Differences are taken at CW+1 bits so no wrap-around can alias a hit.
module box_overlap
  import snake_pkg::*;
(
  input  logic [CW-1:0] xa,
  input  logic [CW-1:0] ya,
  input  logic [CW-1:0] xb,
  input  logic [CW-1:0] yb,
  output logic          hit
);

  localparam logic [CW:0] BLK_W = (CW + 1)'(BLK);

  logic [CW:0] dx;
  logic [CW:0] dy;

  always_comb begin
    dx  = (xa >= xb) ? ({1'b0, xa} - {1'b0, xb}) : ({1'b0, xb} - {1'b0, xa});
    dy  = (ya >= yb) ? ({1'b0, ya} - {1'b0, yb}) : ({1'b0, yb} - {1'b0, ya});
    hit = (dx < BLK_W) && (dy < BLK_W);
  end

endmodule

// File: rtl/food_eat_controller.sv
// Holds the live food square, detects eats on game ticks and respawns from candidates.
// Define SCORE_BCD_EN for a 4-digit packed BCD score; default is saturating binary.
module food_eat_controller
  import snake_pkg::*;
#(
  parameter int unsigned MAX_TRY    = 15,
  parameter int unsigned RST_X      = 320,
  parameter int unsigned RST_Y      = 240,
  parameter logic [15:0] SCORE_INIT = 16'h0000
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          tick,
  input  logic [CW-1:0] x_head,
  input  logic [CW-1:0] y_head,
  input  logic [CW-1:0] x_cand,
  input  logic [CW-1:0] y_cand,
  output logic [CW-1:0] x_food,
  output logic [CW-1:0] y_food,
  output logic          food_valid,
  output logic          grow,
  output logic [15:0]   score,
  output logic          busy
);

  localparam int unsigned TW = (MAX_TRY > 0) ? $clog2(MAX_TRY + 1) : 1;

  food_state_e   state_q, state_d;
  logic [TW-1:0] try_q, try_d;
  logic [CW-1:0] x_food_q, x_food_d;
  logic [CW-1:0] y_food_q, y_food_d;
  logic          valid_q, valid_d;
  logic          grow_q, grow_d;
  logic          busy_q, busy_d;
  logic [15:0]   score_q, score_d;
  logic [15:0]   score_inc;

  logic hit_food;
  logic hit_cand;
  logic cand_new;

  box_overlap u_head_food (
    .xa  (x_head),
    .ya  (y_head),
    .xb  (x_food_q),
    .yb  (y_food_q),
    .hit (hit_food)
  );

  box_overlap u_head_cand (
    .xa  (x_head),
    .ya  (y_head),
    .xb  (x_cand),
    .yb  (y_cand),
    .hit (hit_cand)
  );

  assign cand_new = (x_cand != x_food_q) || (y_cand != y_food_q);

  always_comb begin
`ifdef SCORE_BCD_EN
    score_inc = (score_q == SCORE_MAX) ? score_q : bcd_inc(score_q);
`else
    score_inc = (score_q == SCORE_MAX) ? score_q : score_q + 16'd1;
`endif
  end

  always_comb begin
    state_d  = state_q;
    try_d    = try_q;
    x_food_d = x_food_q;
    y_food_d = y_food_q;
    valid_d  = valid_q;
    grow_d   = 1'b0;
    busy_d   = busy_q;
    score_d  = score_q;
    case (state_q)
      StInit: begin
        state_d = StRespawn;
        busy_d  = 1'b1;
        valid_d = 1'b0;
      end
      StArmed: begin
        valid_d = 1'b1;
        busy_d  = 1'b0;
        if (tick && hit_food) begin
          grow_d  = 1'b1;
          score_d = score_inc;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          state_d = StRespawn;
        end
      end
      StRespawn: begin
        busy_d  = 1'b1;
        valid_d = 1'b0;
        // Retry budget exhausted: take whatever the generator offers.
        if ((!hit_cand && cand_new) || (try_q == TW'(MAX_TRY))) begin
          x_food_d = x_cand;
          y_food_d = y_cand;
          try_d    = '0;
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = StArmed;
        end else begin
          try_d = try_q + TW'(1);
        end
      end
      default: begin
        state_d = StInit;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        try_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q  <= StInit;
      try_q    <= '0;
      x_food_q <= CW'(RST_X);
      y_food_q <= CW'(RST_Y);
      valid_q  <= 1'b0;
      grow_q   <= 1'b0;
      busy_q   <= 1'b0;
      score_q  <= SCORE_INIT;
    end else begin
      state_q  <= state_d;
      try_q    <= try_d;
      x_food_q <= x_food_d;
      y_food_q <= y_food_d;
      valid_q  <= valid_d;
      grow_q   <= grow_d;
      busy_q   <= busy_d;
      score_q  <= score_d;
    end
  end

  assign x_food     = x_food_q;
  assign y_food     = y_food_q;
  assign food_valid = valid_q;
  assign grow       = grow_q;
  assign busy       = busy_q;
  assign score      = score_q;

endmodule
